// File: rtl/guia_1106_pkg.sv
// Shared types and framing constants for the guia_1106 serial frame transmitter.
package guia11_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    DATA  = 3'd2,
    POST  = 3'd3,
    GAP_S = 3'd4
  } state_t;

  localparam logic [2:0] PREAMBLE  = 3'b101;
  localparam logic [2:0] POSTAMBLE = 3'b010;

  // Marker bits go out left to right: idx 0 selects pat[2].
  function automatic logic marker_bit(input logic [2:0] pat, input logic [1:0] idx);
    logic [2:0] t;
    t = pat << idx;
    return t[2];
  endfunction

endpackage

// File: rtl/guia_1106_if.sv
// Parallel-in handshake plus serial/status outputs of the frame transmitter.
interface guia_1106_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              s;
  logic              busy;
  logic              frame_done;

  modport master (output data_in, valid, input ready, s, busy, frame_done);
  modport slave  (input data_in, valid, output ready, s, busy, frame_done);
endinterface

// File: rtl/guia_1106_piso_shift.sv
// Parallel-load, MSB-first shift register holding the payload copy for a frame.
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              q_msb
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= q << 1;
  end

  assign q_msb = q[DATA_W-1];

endmodule

// File: rtl/guia_1106.sv
// Serial frame transmitter: 101 preamble, MSB-first payload, 010 postamble, idle gap.
//
// state | meaning
// IDLE  | line at IDLE_LVL, ready for a new word
// PRE   | sending preamble 1,0,1
// DATA  | sending payload MSB first
// POST  | sending postamble 0,1,0
// GAP_S | line at IDLE_LVL, not yet ready
module guia_1106
  import guia11_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter int   GAP      = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  guia_1106_if.slave  bus
);

  localparam int MAX_A = (DATA_W > 3) ? DATA_W : 3;
  localparam int MAX_C = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             s_q, s_nx;
  logic             fd_q, fd_nx;
  logic             load, shift, q_msb;

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     (bus.data_in),
    .q_msb (q_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      s_q   <= IDLE_LVL;
      fd_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      s_q   <= s_nx;
      fd_q  <= fd_nx;
    end
  end

  // s and frame_done are computed from the upcoming state so they line up with it.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    s_nx     = IDLE_LVL;
    fd_nx    = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.valid) begin
          state_nx = PRE;
          load     = 1'b1;
        end
      end
      PRE:   if (cnt == MARK_LAST) begin state_nx = DATA; cnt_nx = '0; end
      DATA:  if (cnt == DATA_LAST) begin state_nx = POST; cnt_nx = '0; end
      POST: begin
        if (cnt == MARK_LAST) begin
          state_nx = (GAP > 0) ? GAP_S : IDLE;
          cnt_nx   = '0;
          fd_nx    = 1'b1;
        end
      end
      GAP_S: if (cnt == GAP_LAST) begin state_nx = IDLE; cnt_nx = '0; end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    case (state_nx)
      PRE:     s_nx = marker_bit(PREAMBLE, cnt_nx[1:0]);
      DATA:    s_nx = q_msb;
      POST:    s_nx = marker_bit(POSTAMBLE, cnt_nx[1:0]);
      default: s_nx = IDLE_LVL;
    endcase
    shift = (state_nx == DATA);
  end

  assign bus.ready      = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.s          = s_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_guia_1106.sv
// Directed + randomized checks of guia_1106 against a frame-level reference model.
module tb_guia_1106;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   passed = 0;
  int   total  = 0;
  logic [13:0] cap;

  always #5 clk = ~clk;

  guia_1106_if #(.DATA_W(8)) ifa ();
  guia_1106_if #(.DATA_W(4)) ifb ();

  guia_1106 #(.DATA_W(8), .GAP(2), .IDLE_LVL(1'b0)) dut_a (.clk(clk), .reset(reset_a), .bus(ifa));
  guia_1106 #(.DATA_W(4), .GAP(0), .IDLE_LVL(1'b1)) dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Cycle j (1-based) is the j-th cycle after the accept edge.
  task automatic frame_a(input logic [7:0] d, input bit hold, input logic [7:0] nxt, input bit noise);
    logic [13:0] stream;
    logic        exp_s;
    stream = {3'b101, d, 3'b010};
    ifa.data_in = d;
    ifa.valid   = 1'b1;
    chk("a_ready_before_accept", ifa.ready, 1);
    for (int j = 1; j <= 17; j++) begin
      step();
      if (j == 1) begin
        if (hold) ifa.data_in = nxt;
        else      ifa.valid   = 1'b0;
      end
      if (noise && j < 16) begin
        ifa.valid   = 1'($urandom_range(0, 1));
        ifa.data_in = 8'($urandom);
      end
      if (noise && j == 16) ifa.valid = 1'b0;
      exp_s = (j <= 14) ? stream[14-j] : 1'b0;
      if (j <= 14) cap[14-j] = ifa.s;
      chk($sformatf("a_s[%0d]", j), ifa.s, exp_s);
      chk($sformatf("a_frame_done[%0d]", j), ifa.frame_done, (j == 15));
      chk($sformatf("a_ready[%0d]", j), ifa.ready, (j >= 17));
      chk($sformatf("a_busy[%0d]", j), ifa.busy, (j < 17));
    end
  endtask

  task automatic frame_b(input logic [3:0] d);
    logic [9:0] stream;
    logic       exp_s;
    stream = {3'b101, d, 3'b010};
    ifb.data_in = d;
    ifb.valid   = 1'b1;
    chk("b_ready_before_accept", ifb.ready, 1);
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j == 1) ifb.valid = 1'b0;
      exp_s = (j <= 10) ? stream[10-j] : 1'b1;
      chk($sformatf("b_s[%0d]", j), ifb.s, exp_s);
      chk($sformatf("b_frame_done[%0d]", j), ifb.frame_done, (j == 11));
      chk($sformatf("b_ready[%0d]", j), ifb.ready, (j >= 11));
    end
  endtask

  initial begin
    logic [13:0] hits;
    logic        seen_fd;
    logic [2:0]  win;

    reset_a = 1'b1; reset_b = 1'b1;
    ifa.valid = 1'b0; ifa.data_in = '0;
    ifb.valid = 1'b0; ifb.data_in = '0;
    step(); step();
    reset_a = 1'b0; reset_b = 1'b0;
    step();
    chk("reset_a_ready", ifa.ready, 1);
    chk("reset_a_busy", ifa.busy, 0);
    chk("reset_a_s", ifa.s, 0);
    chk("reset_a_frame_done", ifa.frame_done, 0);
    chk("reset_b_ready", ifb.ready, 1);
    chk("reset_b_s", ifb.s, 1);

    // Scenario 1 and loopback through a behavioural 010/101 detector.
    frame_a(8'hA5, 1'b0, 8'h00, 1'b0);
    hits = '0;
    for (int i = 2; i < 14; i++) begin
      win = {cap[15-i], cap[14-i], cap[13-i]};
      if (win == 3'b101 || win == 3'b010) hits[i] = 1'b1;
    end
    chk("detector_hits", hits, 14'b11111001100100);

    // Scenario 2: valid held, back-to-back frames at minimum spacing.
    frame_a(8'h00, 1'b1, 8'hFF, 1'b0);
    frame_a(8'hFF, 1'b0, 8'h00, 1'b0);

    // Scenario 3: valid/data noise during a frame.
    frame_a(8'h5A, 1'b0, 8'h00, 1'b1);

    // Scenario 4: reset on the 5th payload bit.
    ifa.data_in = 8'h3C; ifa.valid = 1'b1;
    step();
    ifa.valid = 1'b0;
    repeat (7) step();
    chk("abort_s_5th_bit", ifa.s, 1);
    reset_a = 1'b1;
    step();
    chk("abort_s", ifa.s, 0);
    chk("abort_ready", ifa.ready, 1);
    chk("abort_frame_done", ifa.frame_done, 0);
    reset_a = 1'b0;
    seen_fd = 1'b0;
    repeat (20) begin
      step();
      seen_fd = seen_fd | ifa.frame_done;
    end
    chk("abort_no_frame_done", seen_fd, 0);
    frame_a(8'($urandom), 1'b0, 8'h00, 1'b0);

    // Accept and reset on the same edge: nothing starts.
    ifa.data_in = 8'hC3; ifa.valid = 1'b1; reset_a = 1'b1;
    step();
    ifa.valid = 1'b0; reset_a = 1'b0;
    step();
    chk("accept_reset_ready", ifa.ready, 1);
    chk("accept_reset_s", ifa.s, 0);

    // Randomized payloads.
    repeat (6) frame_a(8'($urandom), 1'b0, 8'h00, 1'b0);

    // Scenario 5: GAP=0, IDLE_LVL=1, DATA_W=4.
    frame_b(4'b1010);
    repeat (4) frame_b(4'($urandom));
    step();
    chk("b_idle_level", ifb.s, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
